// File: rtl/mdu_sequencer.sv
// Iterative radix-2 multiply/divide unit with HI/LO ownership and ID-stage stall term.
// Multiply is shift-add LSB first; divide is restoring MSB first on magnitudes, sign fixed afterwards.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_E,
  input  logic [1:0]       op_E,
  input  logic [WIDTH-1:0] a_E,
  input  logic [WIDTH-1:0] b_E,
  input  logic             mdu_use_D,
  input  logic             mthi_W,
  input  logic             mtlo_W,
  input  logic [WIDTH-1:0] wdata_W,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_mdu
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     b_abs_q, b_abs_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div_zero_q, div_zero_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 sgn_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       rem_sh_s;
  logic [WIDTH:0]       rem_diff_s;
  logic [2*WIDTH-1:0]   prod_s;

  // Next-state, datapath step and HI/LO update logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    acc_d      = acc_q;
    b_abs_d    = b_abs_q;
    a_raw_d    = a_raw_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    busy_d     = busy_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    sgn_s      = ~op_E[0];
    // Multiply: add |b| into the upper half when the current multiplier bit is set, then shift right.
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_abs_q} : {(WIDTH+1){1'b0}});
    // Divide: remainder shifted left with the next dividend bit, trial-subtract |b|.
    rem_sh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff_s = rem_sh_s - {1'b0, b_abs_q};
    prod_s     = neg_quo_q ? neg_2w(acc_q) : acc_q;

    case (state_q)
      IDLE: begin
        hi_d = mthi_W ? wdata_W : hi_q;
        lo_d = mtlo_W ? wdata_W : lo_q;
        if (start_E) begin
          op_d       = op_E;
          acc_d      = {{WIDTH{1'b0}}, ((sgn_s && a_E[WIDTH-1]) ? neg_w(a_E) : a_E)};
          b_abs_d    = (sgn_s && b_E[WIDTH-1]) ? neg_w(b_E) : b_E;
          a_raw_d    = a_E;
          neg_quo_d  = sgn_s && (a_E[WIDTH-1] ^ b_E[WIDTH-1]);
          neg_rem_d  = sgn_s && a_E[WIDTH-1];
          div_zero_d = (b_E == {WIDTH{1'b0}});
          cnt_d      = {CW{1'b0}};
          busy_d     = 1'b1;
          state_d    = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (op_q[1]) begin
          if (!rem_diff_s[WIDTH]) begin
            acc_d = {rem_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = FIX;
        end else begin
          state_d = RUN;
        end
      end
      FIX: begin
        if (op_q[1]) begin
          if (div_zero_q) begin
            lo_d = {WIDTH{1'b1}};
            hi_d = a_raw_q;
          end else begin
            lo_d = neg_quo_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            hi_d = neg_rem_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
          end
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
        cnt_d   = {CW{1'b0}};
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      op_q       <= 2'b00;
      acc_q      <= {(2*WIDTH){1'b0}};
      b_abs_q    <= {WIDTH{1'b0}};
      a_raw_q    <= {WIDTH{1'b0}};
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      b_abs_q    <= b_abs_d;
      a_raw_q    <= a_raw_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  // start_E covers the EX cycle before busy rises.
  assign stall_mdu = mdu_use_D & (busy_q | start_E);

  mdu_sequencer_checker u_chk (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy_q),
    .start_E (start_E),
    .mthi_W  (mthi_W),
    .mtlo_W  (mtlo_W)
  );

endmodule

// Flags protocol violations the hazard logic is expected to prevent.
module mdu_sequencer_checker (
  input logic clk,
  input logic reset,
  input logic busy,
  input logic start_E,
  input logic mthi_W,
  input logic mtlo_W
);

  a_no_start_busy: assert property (@(posedge clk) disable iff (reset) !(busy && start_E));
  a_no_mt_busy:    assert property (@(posedge clk) disable iff (reset) !(busy && (mthi_W || mtlo_W)));

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed table-driven bench for mdu_sequencer plus hand-written reset and same-edge MTHI sequences.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_E;
  logic [1:0]  op_E;
  logic [31:0] a_E, b_E;
  logic        mdu_use_D, mthi_W, mtlo_W;
  logic [31:0] wdata_W;
  logic [31:0] hi, lo;
  logic        busy, stall_mdu;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_d;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[11];

  mdu_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_E(start_E), .op_E(op_E), .a_E(a_E), .b_E(b_E),
    .mdu_use_D(mdu_use_D), .mthi_W(mthi_W), .mtlo_W(mtlo_W), .wdata_W(wdata_W),
    .hi(hi), .lo(lo), .busy(busy), .stall_mdu(stall_mdu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(output int busy_cycles, output int stall_cycles);
    int guard;
    busy_cycles  = 0;
    stall_cycles = 0;
    guard = 0;
    while (busy && guard < 100) begin
      busy_cycles++;
      if (stall_mdu) stall_cycles++;
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, output int busy_cycles, output int stall_cycles);
    int sc;
    @(negedge clk);
    op_E = op; a_E = a; b_E = b; start_E = 1'b1; mdu_use_D = use_d;
    #1;
    sc = stall_mdu ? 1 : 0;
    @(negedge clk);
    start_E = 1'b0;
    wait_idle(busy_cycles, stall_cycles);
    stall_cycles += sc;
  endtask

  initial begin
    int bc, sc;
    reset = 1'b1; start_E = 1'b0; op_E = 2'b00; a_E = 32'h0; b_E = 32'h0;
    mdu_use_D = 1'b1; mthi_W = 1'b0; mtlo_W = 1'b0; wdata_W = 32'h0;

    vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{2'b00, 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{2'b11, 32'd100,      32'd7,        1'b0, 32'd2,        32'd14};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000};
    vecs[6]  = '{2'b11, 32'h00001234, 32'h00000000, 1'b1, 32'h00001234, 32'hFFFFFFFF};
    vecs[7]  = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[8]  = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 1'b1, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{2'b01, 32'h00010000, 32'h00010000, 1'b0, 32'h00000001, 32'h00000000};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_hi", {32'h0, hi}, 64'h0);
    chk("reset_lo", {32'h0, lo}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_stall", {63'h0, stall_mdu}, 64'h0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_d, bc, sc);
      chk($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd33);
      chk($sformatf("v%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].exp_hi});
      chk($sformatf("v%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].exp_lo});
      chk($sformatf("v%0d_stall_cycles", i), 64'(sc), vecs[i].use_d ? 64'd34 : 64'd0);
      chk($sformatf("v%0d_stall_after", i), {63'h0, stall_mdu}, 64'h0);
      mdu_use_D = 1'b0;
    end

    // MTHI on the same edge as start: write lands, then the result overwrites it.
    @(negedge clk);
    op_E = 2'b11; a_E = 32'd100; b_E = 32'd7; start_E = 1'b1;
    mthi_W = 1'b1; mtlo_W = 1'b1; wdata_W = 32'h0000ABCD;
    @(negedge clk);
    start_E = 1'b0; mthi_W = 1'b0; mtlo_W = 1'b0;
    chk("same_edge_mthi", {32'h0, hi}, 64'h0000ABCD);
    chk("same_edge_mtlo", {32'h0, lo}, 64'h0000ABCD);
    chk("same_edge_busy", {63'h0, busy}, 64'h1);
    wait_idle(bc, sc);
    chk("same_edge_cycles", 64'(bc), 64'd33);
    chk("same_edge_hi_final", {32'h0, hi}, 64'd2);
    chk("same_edge_lo_final", {32'h0, lo}, 64'd14);

    // Reset in the middle of a MULTU abandons it.
    @(negedge clk);
    op_E = 2'b01; a_E = 32'hFFFFFFFF; b_E = 32'hFFFFFFFF; start_E = 1'b1;
    @(negedge clk);
    start_E = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", {63'h0, busy}, 64'h0);
    chk("midreset_hi", {32'h0, hi}, 64'h0);
    chk("midreset_lo", {32'h0, lo}, 64'h0);
    mtlo_W = 1'b1; wdata_W = 32'h00000055;
    @(negedge clk);
    mtlo_W = 1'b0;
    chk("mtlo_after_reset", {32'h0, lo}, 64'h55);
    repeat (40) @(negedge clk);
    chk("abandoned_lo", {32'h0, lo}, 64'h55);
    chk("abandoned_hi", {32'h0, hi}, 64'h0);
    chk("abandoned_busy", {63'h0, busy}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
